// File: rtl/bv_lookup_pkg.sv
// bv_lookup_pkg: shared definitions for the bit-vector lookup classifier.
//   - localbus address field positions and widths
//   - status-space field code and status word indices
//   - bus handshake FSM state type
//   - sizing helpers (rule-id width, total chunk-table count)
package bv_lookup_pkg;

   localparam int ADDR_W         = 28;
   localparam int ADDR_FIELD_LSB = 24;
   localparam int ADDR_FIELD_W   = 4;
   localparam int ADDR_CHUNK_LSB = 16;
   localparam int ADDR_CHUNK_W   = 8;
   localparam int ADDR_ENTRY_LSB = 8;
   localparam int ADDR_ENTRY_W   = 8;
   localparam int ADDR_WORD_LSB  = 0;
   localparam int ADDR_WORD_W    = 8;

   localparam logic [3:0] STATUS_FIELD      = 4'hF;
   localparam logic [7:0] STAT_WORD_LOOKUPS = 8'd0;
   localparam logic [7:0] STAT_WORD_HITS    = 8'd1;

   typedef enum logic [1:0] {
      BUS_IDLE   = 2'd0,
      BUS_ACCESS = 2'd1,
      BUS_ACK    = 2'd2,
      BUS_WAIT   = 2'd3
   } bus_state_t;

   function automatic int rule_id_w(input int rule_num);
      return (rule_num > 2) ? $clog2(rule_num) : 1;
   endfunction

   function automatic int chunk_count(input int num_fields, input int field_w, input int chunk_w);
      return num_fields * (field_w / chunk_w);
   endfunction

endpackage

// File: rtl/bv_prio_enc.sv
// bv_prio_enc: lowest-set-bit encoder over a RULE_NUM-bit match vector.
// Outputs are registered (final pipeline stage of the lookup).
// Ports:
//   clk, reset (sync, active low)
//   in_valid, vec          : match vector and its strobe
//   out_valid, index, hit  : registered strobe, lowest set index (0 if none), any-set flag
module bv_prio_enc #(
   parameter int RULE_NUM = 64,
   parameter int ID_W     = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [RULE_NUM-1:0] vec,
   output logic                out_valid,
   output logic [ID_W-1:0]     index,
   output logic                hit
);

   logic [ID_W-1:0] low_idx;
   logic            low_hit;

   // Scanning downward lets the lowest set bit be the last one assigned.
   always_comb begin
      low_idx = '0;
      low_hit = 1'b0;
      for (int i = RULE_NUM - 1; i >= 0; i--) begin
         if (vec[i]) begin
            low_idx = ID_W'(i);
            low_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         index     <= '0;
         hit       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         index     <= low_idx;
         hit       <= low_hit;
      end
   end

endmodule

// File: rtl/bv_lookup.sv
// bv_lookup: bit-vector packet classifier.
// The key is cut into CHUNK_W-bit chunks; chunk c of field f lives at key bits
// [f*FIELD_W + c*CHUNK_W +: CHUNK_W] (chunk 0 is the least significant) and
// indexes its own 2^CHUNK_W-entry table of RULE_NUM-bit rule vectors. All
// vectors are ANDed and the lowest surviving rule is reported.
// Pipeline: key register -> table-read register -> AND + priority encode register.
// Ports:
//   clk, reset               : clock, synchronous active-low reset
//   localbus_*               : table/status access (ale latches address, one-cycle ack_n)
//   packethead_valid/packethead : one key per cycle
//   countid_valid/countid/countid_hit : result, three cycles after the key
//
// Bus FSM states:
//   state      | meaning
//   BUS_IDLE   | waiting for cs_n low; ale latches the address here only
//   BUS_ACCESS | commit write or capture read data
//   BUS_ACK    | ack_n low for this single cycle
//   BUS_WAIT   | wait for cs_n high before accepting another access
module bv_lookup
   import bv_lookup_pkg::*;
#(
   parameter int NUM_FIELDS = 4,
   parameter int FIELD_W    = 32,
   parameter int CHUNK_W    = 4,
   parameter int RULE_NUM   = 64
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             localbus_cs_n,
   input  logic                             localbus_rd_wr,
   input  logic [31:0]                      localbus_data,
   input  logic                             localbus_ale,
   output logic                             localbus_ack_n,
   output logic [31:0]                      localbus_data_out,
   input  logic                             packethead_valid,
   input  logic [NUM_FIELDS*FIELD_W-1:0]    packethead,
   output logic                             countid_valid,
   output logic [rule_id_w(RULE_NUM)-1:0]   countid,
   output logic                             countid_hit
);

   localparam int CPF        = FIELD_W / CHUNK_W;
   localparam int NUM_TABLES = chunk_count(NUM_FIELDS, FIELD_W, CHUNK_W);
   localparam int ENTRIES    = 1 << CHUNK_W;
   localparam int WORDS      = RULE_NUM / 32;
   localparam int MEM_DEPTH  = NUM_TABLES * ENTRIES;
   localparam int MEM_AW     = $clog2(MEM_DEPTH);
   localparam int ID_W       = rule_id_w(RULE_NUM);
   localparam int KEY_W      = NUM_FIELDS * FIELD_W;

   bus_state_t          bus_state;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         lookup_cnt;
   logic [31:0]         hit_cnt;

   // All tables share one flat array: table t, entry e sits at t*ENTRIES + e.
   logic [RULE_NUM-1:0] tbl_q [MEM_DEPTH];

   logic [31:0]         a_field, a_chunk, a_entry, a_word;
   logic                is_table, is_status, tbl_we;
   logic [MEM_AW-1:0]   mem_addr;
   logic [31:0]         word_shift;
   logic [RULE_NUM-1:0] tbl_row, wr_mask, wr_bits;
   logic [31:0]         rd_data;

   assign a_field = 32'(addr_q[ADDR_FIELD_LSB +: ADDR_FIELD_W]);
   assign a_chunk = 32'(addr_q[ADDR_CHUNK_LSB +: ADDR_CHUNK_W]);
   assign a_entry = 32'(addr_q[ADDR_ENTRY_LSB +: ADDR_ENTRY_W]);
   assign a_word  = 32'(addr_q[ADDR_WORD_LSB +: ADDR_WORD_W]);

   assign is_table  = (a_field < NUM_FIELDS) && (a_chunk < CPF) &&
                      (a_entry < ENTRIES) && (a_word < WORDS);
   assign is_status = (addr_q[ADDR_FIELD_LSB +: ADDR_FIELD_W] == STATUS_FIELD);

   assign mem_addr   = MEM_AW'((a_field * CPF + a_chunk) * ENTRIES + a_entry);
   assign word_shift = a_word * 32;
   assign tbl_row    = tbl_q[mem_addr];
   assign wr_mask    = RULE_NUM'(32'hFFFF_FFFF) << word_shift;
   assign wr_bits    = RULE_NUM'(localbus_data) << word_shift;
   assign tbl_we     = (bus_state == BUS_ACCESS) && !localbus_rd_wr && is_table;

   always_comb begin
      rd_data = '0;
      if (is_status) begin
         if (addr_q[ADDR_WORD_LSB +: ADDR_WORD_W] == STAT_WORD_LOOKUPS)
            rd_data = lookup_cnt;
         else if (addr_q[ADDR_WORD_LSB +: ADDR_WORD_W] == STAT_WORD_HITS)
            rd_data = hit_cnt;
      end else if (is_table) begin
         rd_data = 32'(tbl_row >> word_shift);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus_state         <= BUS_IDLE;
         addr_q            <= '0;
         localbus_ack_n    <= 1'b1;
         localbus_data_out <= '0;
      end else begin
         case (bus_state)
            BUS_IDLE: begin
               if (localbus_ale)
                  addr_q <= localbus_data[ADDR_W-1:0];
               if (!localbus_cs_n)
                  bus_state <= BUS_ACCESS;
            end
            BUS_ACCESS: begin
               if (localbus_rd_wr)
                  localbus_data_out <= rd_data;
               localbus_ack_n <= 1'b0;
               bus_state      <= BUS_ACK;
            end
            BUS_ACK: begin
               localbus_ack_n <= 1'b1;
               bus_state      <= BUS_WAIT;
            end
            BUS_WAIT: begin
               if (localbus_cs_n)
                  bus_state <= BUS_IDLE;
            end
            default: bus_state <= BUS_IDLE;
         endcase
      end
   end

   // Write commits on the edge closing ACCESS; a stage-1 read in that same
   // cycle still sees the old row.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < MEM_DEPTH; i++)
            tbl_q[i] <= '0;
      end else if (tbl_we) begin
         tbl_q[mem_addr] <= (tbl_row & ~wr_mask) | (wr_bits & wr_mask);
      end
   end

   logic                key_v_q, vec_v_q;
   logic [KEY_W-1:0]    key_q;
   logic [RULE_NUM-1:0] vec_q [NUM_TABLES];
   logic [RULE_NUM-1:0] and_vec;

   // Chunk t of the key is exactly key bits [t*CHUNK_W +: CHUNK_W].
   always_ff @(posedge clk) begin
      if (!reset) begin
         key_v_q <= 1'b0;
         key_q   <= '0;
         vec_v_q <= 1'b0;
         for (int t = 0; t < NUM_TABLES; t++)
            vec_q[t] <= '0;
      end else begin
         key_v_q <= packethead_valid;
         key_q   <= packethead;
         vec_v_q <= key_v_q;
         for (int t = 0; t < NUM_TABLES; t++)
            vec_q[t] <= tbl_q[MEM_AW'(t * ENTRIES) + MEM_AW'(key_q[t*CHUNK_W +: CHUNK_W])];
      end
   end

   always_comb begin
      and_vec = '1;
      for (int t = 0; t < NUM_TABLES; t++)
         and_vec = and_vec & vec_q[t];
   end

   bv_prio_enc #(
      .RULE_NUM (RULE_NUM),
      .ID_W     (ID_W)
   ) u_prio_enc (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vec_v_q),
      .vec       (and_vec),
      .out_valid (countid_valid),
      .index     (countid),
      .hit       (countid_hit)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         lookup_cnt <= '0;
         hit_cnt    <= '0;
      end else if (countid_valid) begin
         lookup_cnt <= lookup_cnt + 32'd1;
         if (countid_hit)
            hit_cnt <= hit_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_bv_lookup.sv
// tb_bv_lookup: randomized self-checking bench for bv_lookup.
// Reference model keeps, per rule, the set of allowed values for every chunk
// of the key; a rule matches when every chunk value is allowed.
module tb_bv_lookup;

   localparam int NF  = 4;
   localparam int FW  = 32;
   localparam int CW  = 4;
   localparam int RN  = 64;
   localparam int CPF = FW / CW;
   localparam int NT  = NF * CPF;
   localparam int ENT = 1 << CW;
   localparam int KW  = NF * FW;
   localparam int IDW = 6;

   logic           clk = 1'b0;
   logic           reset;
   logic           localbus_cs_n, localbus_rd_wr, localbus_ale;
   logic [31:0]    localbus_data;
   logic           localbus_ack_n;
   logic [31:0]    localbus_data_out;
   logic           packethead_valid;
   logic [KW-1:0]  packethead;
   logic           countid_valid;
   logic [IDW-1:0] countid;
   logic           countid_hit;

   bv_lookup #(
      .NUM_FIELDS (NF),
      .FIELD_W    (FW),
      .CHUNK_W    (CW),
      .RULE_NUM   (RN)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .localbus_cs_n     (localbus_cs_n),
      .localbus_rd_wr    (localbus_rd_wr),
      .localbus_data     (localbus_data),
      .localbus_ale      (localbus_ale),
      .localbus_ack_n    (localbus_ack_n),
      .localbus_data_out (localbus_data_out),
      .packethead_valid  (packethead_valid),
      .packethead        (packethead),
      .countid_valid     (countid_valid),
      .countid           (countid),
      .countid_hit       (countid_hit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int due;
      int id;
      bit hit;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   allow [RN][NT][ENT];
   int   exp_lookups = 0;
   int   exp_hits    = 0;
   int   n_pass      = 0;
   int   n_total     = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int r = 0; r < RN; r++)
         for (int t = 0; t < NT; t++)
            for (int e = 0; e < ENT; e++)
               allow[r][t][e] = 1'b0;
      exp_lookups = 0;
      exp_hits    = 0;
   endfunction

   function automatic logic [31:0] mk_addr(input int f, input int c, input int e, input int w);
      return {4'h0, 4'(f), 8'(c), 8'(e), 8'(w)};
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
      int f, c, e, w;
      f = int'(addr[27:24]); c = int'(addr[23:16]); e = int'(addr[15:8]); w = int'(addr[7:0]);
      if (f < NF && c < CPF && e < ENT && w < RN / 32)
         for (int b = 0; b < 32; b++)
            allow[w*32 + b][f*CPF + c][e] = data[b];
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int f, c, e, w;
      logic [31:0] d;
      f = int'(addr[27:24]); c = int'(addr[23:16]); e = int'(addr[15:8]); w = int'(addr[7:0]);
      d = '0;
      if (f == 15) begin
         if (w == 0) d = 32'(exp_lookups);
         else if (w == 1) d = 32'(exp_hits);
      end else if (f < NF && c < CPF && e < ENT && w < RN / 32) begin
         for (int b = 0; b < 32; b++)
            d[b] = allow[w*32 + b][f*CPF + c][e];
      end
      return d;
   endfunction

   function automatic void model_lookup(input logic [KW-1:0] key, output int id, output bit hit);
      bit ok;
      int v;
      hit = 1'b0;
      id  = 0;
      for (int r = 0; r < RN; r++) begin
         ok = 1'b1;
         for (int f = 0; f < NF; f++)
            for (int c = 0; c < CPF; c++) begin
               v = int'(key[f*FW + c*CW +: CW]);
               if (!allow[r][f*CPF + c][v]) ok = 1'b0;
            end
         if (ok && !hit) begin
            hit = 1'b1;
            id  = r;
         end
      end
   endfunction

   // Called just after an edge with the key already driven for the coming cycle.
   task automatic push_key(input logic [KW-1:0] key);
      exp_t e;
      int   id;
      bit   hit;
      model_lookup(key, id, hit);
      e.due = cyc + 3;
      e.id  = id;
      e.hit = hit;
      exp_q.push_back(e);
      exp_lookups++;
      if (hit) exp_hits++;
   endtask

   always @(negedge clk) begin
      if (countid_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(countid_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result_cycle", 32'(cyc), 32'(mon_e.due));
            chk("countid", 32'(countid), 32'(mon_e.id));
            chk("countid_hit", 32'(countid_hit), 32'(mon_e.hit));
         end
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
         chk("missing_valid", 32'(countid_valid), 32'd1);
         void'(exp_q.pop_front());
      end
   end

   function automatic logic [KW-1:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_keys(input logic [KW-1:0] key);
      packethead       = key;
      packethead_valid = 1'b1;
      push_key(key);
      tick();
      packethead_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
      tick();
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // One localbus access. With coll set, the key is driven in the cs_n-fall
   // cycle (its table read coincides with ACCESS) and again one cycle later.
   task automatic bus_access(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                             input int hold, input bit coll, input logic [KW-1:0] key,
                             output logic [31:0] rdata);
      int          n;
      int          extra;
      logic [31:0] exp_rd;
      localbus_ale  = 1'b1;
      localbus_data = addr;
      tick();
      localbus_ale   = 1'b0;
      localbus_data  = wdata;
      localbus_rd_wr = rd;
      localbus_cs_n  = 1'b0;
      exp_rd = model_read(addr);
      if (coll) begin
         packethead       = key;
         packethead_valid = 1'b1;
         push_key(key);
      end
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) begin
            if (!rd) model_write(addr, wdata);
            if (coll) push_key(key);
         end else begin
            packethead_valid = 1'b0;
         end
      end while (localbus_ack_n !== 1'b0 && n < 8);
      packethead_valid = 1'b0;
      chk("ack_latency", 32'(n), 32'd2);
      rdata = localbus_data_out;
      if (rd) chk("rd_data", localbus_data_out, exp_rd);
      extra = 0;
      for (int i = 0; i < hold + 1; i++) begin
         tick();
         if (localbus_ack_n !== 1'b1) extra++;
      end
      chk("single_ack", 32'(extra), 32'd0);
      localbus_cs_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      bus_access(1'b0, addr, data, 0, 1'b0, '0, dummy);
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
      bus_access(1'b1, addr, 32'h0, 0, 1'b0, '0, data);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      model_clear();
      tick();
   endtask

   logic [KW-1:0] key_k, key_x;
   logic [31:0]   rdata;
   logic [31:0]   v32;

   initial begin
      reset            = 1'b0;
      localbus_cs_n    = 1'b1;
      localbus_rd_wr   = 1'b1;
      localbus_ale     = 1'b0;
      localbus_data    = '0;
      packethead_valid = 1'b0;
      packethead       = '0;
      model_clear();
      repeat (3) tick();
      chk("rst_ack_n", 32'(localbus_ack_n), 32'd1);
      chk("rst_data_out", localbus_data_out, 32'd0);
      chk("rst_valid", 32'(countid_valid), 32'd0);
      chk("rst_countid", 32'(countid), 32'd0);
      chk("rst_hit", 32'(countid_hit), 32'd0);
      reset = 1'b1;
      tick();

      // Empty tables: nothing matches.
      send_keys(rand_key());
      drain();

      // Rule 3 matches exactly key_k; eight back-to-back alternating keys.
      do_reset();
      key_k = rand_key();
      key_k[31:0] = 32'h1234_5678;
      for (int t = 0; t < NT; t++)
         bus_wr(mk_addr(t / CPF, t % CPF, int'(key_k[t*CW +: CW]), 0), 32'h0000_0008);
      packethead_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         key_x = key_k;
         if (i % 2 == 1) key_x[$urandom_range(KW - 1)] = ~key_x[$urandom_range(KW - 1)];
         if (i % 2 == 1) key_x[0] = ~key_k[0];
         packethead = key_x;
         push_key(key_x);
         tick();
      end
      packethead_valid = 1'b0;
      drain();
      bus_rd(mk_addr(15, 0, 0, 0), rdata);
      chk("lookup_cnt_8", rdata, 32'd8);
      bus_rd(mk_addr(15, 0, 0, 1), rdata);
      chk("hit_cnt_4", rdata, 32'd4);

      // Clear rule 3 in table 0 while key_k reads it: first copy old, second new.
      begin
         v32 = 32'h0;
         bus_access(1'b0, mk_addr(0, 0, int'(key_k[CW-1:0]), 0), v32, 0, 1'b1, key_k, rdata);
      end
      drain();

      // Rule 5: field0 == 0xA5, other fields don't-care.
      for (int c = 0; c < CPF; c++)
         bus_wr(mk_addr(0, c, (c == 0) ? 5 : (c == 1) ? 10 : 0, 0), 32'h0000_0020);
      for (int f = 1; f < NF; f++)
         for (int c = 0; c < CPF; c++)
            for (int e = 0; e < ENT; e++)
               bus_wr(mk_addr(f, c, e, 0), 32'h0000_0020);
      for (int i = 0; i < 3; i++) begin
         key_x = rand_key();
         key_x[31:0] = 32'h0000_00A5;
         send_keys(key_x);
      end
      key_x[31:0] = 32'h0000_00A4;
      send_keys(key_x);
      send_keys(rand_key());
      drain();

      // Rule 40 (word 1, bit 8) on the same pattern: rule 5 still wins.
      for (int c = 0; c < CPF; c++)
         bus_wr(mk_addr(0, c, (c == 0) ? 5 : (c == 1) ? 10 : 0, 1), 32'h0000_0100);
      for (int f = 1; f < NF; f++)
         for (int c = 0; c < CPF; c++)
            for (int e = 0; e < ENT; e++)
               bus_wr(mk_addr(f, c, e, 1), 32'h0000_0100);
      key_x = rand_key();
      key_x[31:0] = 32'h0000_00A5;
      send_keys(key_x);
      drain();
      bus_wr(mk_addr(0, 1, 10, 0), 32'h0000_0000);
      send_keys(key_x);
      key_x[31:0] = 32'h0000_00B5;
      send_keys(key_x);
      drain();

      // Readback, out-of-range and status-space corners.
      bus_rd(mk_addr(0, 1, 10, 1), rdata);
      chk("readback_rule40", rdata, 32'h0000_0100);
      bus_wr(mk_addr(7, 0, 0, 0), 32'hFFFF_FFFF);
      bus_access(1'b1, mk_addr(7, 0, 0, 0), 32'h0, 5, 1'b0, '0, rdata);
      chk("oor_read_zero", rdata, 32'd0);
      bus_rd(mk_addr(0, 0, 0, 2), rdata);
      bus_rd(mk_addr(15, 0, 0, 2), rdata);
      bus_rd(mk_addr(15, 0, 0, 0), rdata);
      bus_rd(mk_addr(15, 0, 0, 1), rdata);
      key_x = rand_key();
      key_x[31:0] = 32'h0000_00A5;
      send_keys(key_x);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
